// File: rtl/uart_rx_fifo.sv
// Byte FIFO between a UART receiver and a loader/RAM writer.
// First-word-fall-through output, sticky overflow flag, synchronous flush.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic [DATA_WIDTH-1:0]        in_data_i,
    input  logic                         in_data_vld_i,
    output logic                         in_data_rdy_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic                         out_data_vld_o,
    input  logic                         out_data_rdy_i,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Handshake flags depend only on registered occupancy.
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_data_vld_i && !w_full;
    assign w_pop   = !w_empty && out_data_rdy_i;

    assign in_data_rdy_o  = !w_full;
    assign out_data_vld_o = !w_empty;
    assign out_data_o     = r_mem[r_rd_ptr];
    assign level_o        = r_level;
    assign overflow_o     = r_overflow;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PTR_W'(r_wr_ptr + PTR_W'(1));
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(r_rd_ptr + PTR_W'(1));
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= LVL_W'(r_level + LVL_W'(1));
                2'b01:   r_level <= LVL_W'(r_level - LVL_W'(1));
                default: r_level <= r_level;
            endcase
            // Sticky until flush or reset: a byte was offered while full.
            if (in_data_vld_i && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DATA_WIDTH=8, DEPTH=16).
module tb_uart_rx_fifo;

    logic       clk_i;
    logic       rst_n_i;
    logic       flush_i;
    logic [7:0] in_data_i;
    logic       in_data_vld_i;
    logic       in_data_rdy_o;
    logic [7:0] out_data_o;
    logic       out_data_vld_o;
    logic       out_data_rdy_i;
    logic [4:0] level_o;
    logic       overflow_o;

    int n_checks;
    int n_errors;

    uart_rx_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (16)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (flush_i),
        .in_data_i     (in_data_i),
        .in_data_vld_i (in_data_vld_i),
        .in_data_rdy_o (in_data_rdy_o),
        .out_data_o    (out_data_o),
        .out_data_vld_o(out_data_vld_o),
        .out_data_rdy_i(out_data_rdy_i),
        .level_o       (level_o),
        .overflow_o    (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_seq(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            in_data_i     = 8'(first + i);
            in_data_vld_i = 1'b1;
            tick();
        end
        in_data_vld_i = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n_i        = 1'b0;
        flush_i        = 1'b0;
        in_data_i      = 8'h00;
        in_data_vld_i  = 1'b0;
        out_data_rdy_i = 1'b0;

        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_level", 32'(level_o), 32'd0);
        check_eq("rst_vld", 32'(out_data_vld_o), 32'd0);
        check_eq("rst_rdy", 32'(in_data_rdy_o), 32'd1);
        check_eq("rst_ovf", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // Single byte, fall-through latency 1, held while consumer stalls.
        in_data_i     = 8'hA5;
        in_data_vld_i = 1'b1;
        tick();
        in_data_vld_i = 1'b0;
        check_eq("a5_vld", 32'(out_data_vld_o), 32'd1);
        check_eq("a5_data", 32'(out_data_o), 32'hA5);
        check_eq("a5_level", 32'(level_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("a5_hold", 32'(out_data_o), 32'hA5);
        end
        out_data_rdy_i = 1'b1;
        tick();
        out_data_rdy_i = 1'b0;
        check_eq("a5_drained", 32'(level_o), 32'd0);

        // Empty: pop request ignored, simultaneous push proceeds.
        in_data_i      = 8'h77;
        in_data_vld_i  = 1'b1;
        out_data_rdy_i = 1'b1;
        tick();
        in_data_vld_i  = 1'b0;
        out_data_rdy_i = 1'b0;
        check_eq("empty_pp_level", 32'(level_o), 32'd1);
        check_eq("empty_pp_data", 32'(out_data_o), 32'h77);
        out_data_rdy_i = 1'b1;
        tick();
        out_data_rdy_i = 1'b0;

        // Fill to DEPTH then drain in order.
        push_seq(0, 16);
        check_eq("full_level", 32'(level_o), 32'd16);
        check_eq("full_rdy", 32'(in_data_rdy_o), 32'd0);
        check_eq("full_ovf", 32'(overflow_o), 32'd0);
        out_data_rdy_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_data", 32'(out_data_o), 32'(i));
            tick();
        end
        out_data_rdy_i = 1'b0;
        check_eq("drain_level", 32'(level_o), 32'd0);
        check_eq("drain_vld", 32'(out_data_vld_o), 32'd0);

        // Full with push and pop offered: pop only, overflow sets.
        push_seq(0, 16);
        in_data_i      = 8'h55;
        in_data_vld_i  = 1'b1;
        out_data_rdy_i = 1'b1;
        tick();
        in_data_vld_i  = 1'b0;
        out_data_rdy_i = 1'b0;
        check_eq("ovf_level", 32'(level_o), 32'd15);
        check_eq("ovf_flag", 32'(overflow_o), 32'd1);
        check_eq("ovf_rdy", 32'(in_data_rdy_o), 32'd1);
        out_data_rdy_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check_eq("ovf_drain", 32'(out_data_o), 32'(i));
            tick();
        end
        out_data_rdy_i = 1'b0;
        check_eq("ovf_empty", 32'(level_o), 32'd0);
        check_eq("ovf_sticky", 32'(overflow_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("ovf_cleared", 32'(overflow_o), 32'd0);

        // Steady state at level 5 with push and pop every cycle; pointers wrap.
        push_seq(0, 5);
        in_data_vld_i  = 1'b1;
        out_data_rdy_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_data_i = 8'(5 + k);
            check_eq("pp_head", 32'(out_data_o), 32'(k));
            tick();
            check_eq("pp_level", 32'(level_o), 32'd5);
        end
        in_data_vld_i = 1'b0;
        for (int k = 40; k < 45; k++) begin
            check_eq("pp_tail", 32'(out_data_o), 32'(k));
            tick();
        end
        out_data_rdy_i = 1'b0;
        check_eq("pp_empty", 32'(level_o), 32'd0);

        // Level 7 with overflow, flush clears despite push/pop offered.
        push_seq(8'h20, 16);
        in_data_i     = 8'hEE;
        in_data_vld_i = 1'b1;
        tick();
        in_data_vld_i = 1'b0;
        check_eq("fl_ovf_set", 32'(overflow_o), 32'd1);
        out_data_rdy_i = 1'b1;
        repeat (9) tick();
        out_data_rdy_i = 1'b0;
        check_eq("fl_pre_level", 32'(level_o), 32'd7);
        check_eq("fl_pre_head", 32'(out_data_o), 32'h29);
        flush_i        = 1'b1;
        in_data_i      = 8'h99;
        in_data_vld_i  = 1'b1;
        out_data_rdy_i = 1'b1;
        tick();
        flush_i        = 1'b0;
        in_data_vld_i  = 1'b0;
        out_data_rdy_i = 1'b0;
        check_eq("fl_level", 32'(level_o), 32'd0);
        check_eq("fl_ovf", 32'(overflow_o), 32'd0);
        check_eq("fl_vld", 32'(out_data_vld_o), 32'd0);
        check_eq("fl_rdy", 32'(in_data_rdy_o), 32'd1);

        // Asynchronous reset mid-cycle at level 9.
        push_seq(8'h40, 9);
        check_eq("ar_pre_level", 32'(level_o), 32'd9);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("ar_level", 32'(level_o), 32'd0);
        check_eq("ar_vld", 32'(out_data_vld_o), 32'd0);
        check_eq("ar_rdy", 32'(in_data_rdy_o), 32'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        in_data_i     = 8'h3C;
        in_data_vld_i = 1'b1;
        tick();
        in_data_i     = 8'hC3;
        tick();
        in_data_vld_i = 1'b0;
        check_eq("ar_data", 32'(out_data_o), 32'h3C);
        check_eq("ar_level2", 32'(level_o), 32'd2);
        out_data_rdy_i = 1'b1;
        tick();
        out_data_rdy_i = 1'b0;
        check_eq("ar_next", 32'(out_data_o), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
